// File: rtl/arb3_rr_ctrl.sv
// -----------------------------------------------------------------------------
// arb3_rr_ctrl
//
// Round-robin ownership controller for a shared 3:1 mux datapath. Three
// requesters raise req[i]; one of them is made owner and keeps the datapath
// until it pulses done or drops its request. The mux select is driven
// straight from this block's select output.
//
// Ports
//   clk      in   1  system clock, all state changes on the rising edge
//   reset    in   1  synchronous, active-high; overrides every other input
//   req      in   3  request per requester, req[i] is requester i
//   done     in   1  owner release pulse, only looked at while busy
//   grant    out  3  one-hot owner, 000 when idle (registered)
//   select   out  2  mux select 00/01/10 = owner 0/1/2, 11 when idle
//   valid    out  1  |grant, qualifies the mux output
//   timeout  out  1  one-cycle pulse on a forced release
//
// Handshake: an owner holds the datapath from the cycle grant appears until
// the edge at which it presents done=1 or req[o]=0. That same edge
// re-arbitrates, so a waiting requester sees its grant in the very next
// cycle with no idle gap. Requests from non-owners never disturb an owner.
//
// Configuration
//   ARB_TIMEOUT_EN  when defined, an owner is force-released after MAX_HOLD
//                   grant cycles and timeout pulses. When undefined there is
//                   no hold counter and timeout stays 0.
//   MAX_HOLD        forced-release length in cycles, legal range 2..255.
//
// State is held in r_state (arb_state_t) so checkers can bind to it.
// -----------------------------------------------------------------------------
module arb3_rr_ctrl #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] req,
  input  logic       done,
  output logic [2:0] grant,
  output logic [1:0] select,
  output logic       valid,
  output logic       timeout
);

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("arb3_rr_ctrl: MAX_HOLD must be in 2..255");
  end

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } arb_state_t;

  arb_state_t r_state;
  logic [2:0] r_grant;
  logic [1:0] r_select;
  logic       r_valid;
  logic       r_timeout;
  // Last owner; the scan for the next winner starts one past it.
  logic [1:0] r_last;

  logic [1:0] w_c0;
  logic [1:0] w_c1;
  logic [1:0] w_c2;
  logic       w_any;
  logic [1:0] w_win;
  logic [2:0] w_win_onehot;
  logic       w_owner_req;
  logic       w_force;
  logic       w_release;

  // Scan order last+1, last+2, last+3 (mod 3). Because r_last always equals
  // the current owner while busy, the owner naturally lands last in the scan,
  // which is what both a done-release re-grant and a preemption need.
  always_comb begin
    w_c0 = 2'd0;
    w_c1 = 2'd1;
    w_c2 = 2'd2;
    case (r_last)
      2'd0: begin
        w_c0 = 2'd1;
        w_c1 = 2'd2;
        w_c2 = 2'd0;
      end
      2'd1: begin
        w_c0 = 2'd2;
        w_c1 = 2'd0;
        w_c2 = 2'd1;
      end
      default: begin
        w_c0 = 2'd0;
        w_c1 = 2'd1;
        w_c2 = 2'd2;
      end
    endcase
  end

  always_comb begin
    w_any = |req;
    w_win = w_c2;
    if (req[w_c0]) begin
      w_win = w_c0;
    end else if (req[w_c1]) begin
      w_win = w_c1;
    end
  end

  always_comb begin
    w_win_onehot = 3'b000;
    case (w_win)
      2'd0:    w_win_onehot = 3'b001;
      2'd1:    w_win_onehot = 3'b010;
      default: w_win_onehot = 3'b100;
    endcase
  end

  // Owner still requesting; r_grant is one-hot while busy.
  assign w_owner_req = |(req & r_grant);

`ifdef ARB_TIMEOUT_EN
  // Counts completed busy cycles of the current owner. Reaching MAX_HOLD-1
  // means the owner has held grant for MAX_HOLD cycles by the next edge.
  logic [7:0] r_hold;
  assign w_force = (r_hold == 8'(MAX_HOLD - 1));
`else
  assign w_force = 1'b0;
`endif

  assign w_release = done | ~w_owner_req | w_force;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_grant   <= 3'b000;
      r_select  <= 2'b11;
      r_valid   <= 1'b0;
      r_timeout <= 1'b0;
      r_last    <= 2'd2;
`ifdef ARB_TIMEOUT_EN
      r_hold    <= 8'd0;
`endif
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_state  <= ST_BUSY;
            r_grant  <= w_win_onehot;
            r_select <= w_win;
            r_valid  <= 1'b1;
            r_last   <= w_win;
`ifdef ARB_TIMEOUT_EN
            r_hold   <= 8'd0;
`endif
          end
        end
        ST_BUSY: begin
          if (w_release) begin
            // Timeout only flags releases that happened purely by force.
            r_timeout <= w_force & ~done & w_owner_req;
            if (w_any) begin
              r_state  <= ST_BUSY;
              r_grant  <= w_win_onehot;
              r_select <= w_win;
              r_valid  <= 1'b1;
              r_last   <= w_win;
            end else begin
              r_state  <= ST_IDLE;
              r_grant  <= 3'b000;
              r_select <= 2'b11;
              r_valid  <= 1'b0;
            end
`ifdef ARB_TIMEOUT_EN
            r_hold <= 8'd0;
`endif
          end else begin
`ifdef ARB_TIMEOUT_EN
            if (r_hold != 8'(MAX_HOLD)) begin
              r_hold <= r_hold + 8'd1;
            end
`endif
          end
        end
        default: begin
          r_state  <= ST_IDLE;
          r_grant  <= 3'b000;
          r_select <= 2'b11;
          r_valid  <= 1'b0;
        end
      endcase
    end
  end

  assign grant   = r_grant;
  assign select  = r_select;
  assign valid   = r_valid;
  assign timeout = r_timeout;

endmodule

// File: tb/tb_arb3_rr_ctrl.sv
module tb_arb3_rr_ctrl;

  localparam int MAX_HOLD = 4;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] req = 3'b000;
  logic       done = 1'b0;
  logic [2:0] grant;
  logic [1:0] select;
  logic       valid;
  logic       timeout;

  always #5 clk = ~clk;

  arb3_rr_ctrl #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .done    (done),
    .grant   (grant),
    .select  (select),
    .valid   (valid),
    .timeout (timeout)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- reference model ----------------
  // Owner as an integer (-1 = nobody), last owner, cycles held, timeout flag.
  int m_owner = -1;
  int m_last  = 2;
  int m_hold  = 0;
  bit m_to    = 1'b0;

  task automatic model_pick(input logic [2:0] rq);
    bit found;
    found = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      int i;
      i = (m_last + k) % 3;
      if (!found && rq[i]) begin
        found   = 1'b1;
        m_owner = i;
        m_last  = i;
        m_hold  = 0;
      end
    end
    if (!found) begin
      m_owner = -1;
      m_hold  = 0;
    end
  endtask

  task automatic model_edge(input logic rs, input logic [2:0] rq, input logic dn);
    bit forced;
    if (rs) begin
      m_owner = -1;
      m_last  = 2;
      m_hold  = 0;
      m_to    = 1'b0;
    end else begin
      m_to = 1'b0;
      if (m_owner < 0) begin
        if (rq != 3'b000) model_pick(rq);
      end else begin
        forced = 1'b0;
`ifdef ARB_TIMEOUT_EN
        forced = (m_hold + 1 >= MAX_HOLD);
`endif
        if (dn || !rq[m_owner] || forced) begin
          m_to = forced && !dn && rq[m_owner];
          model_pick(rq);
        end else if (m_hold < MAX_HOLD) begin
          m_hold = m_hold + 1;
        end
      end
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    logic [2:0] eg;
    logic [1:0] es;
    eg = 3'b000;
    es = 2'b11;
    if (m_owner >= 0) begin
      eg[m_owner] = 1'b1;
      es = 2'(m_owner);
    end
    check("grant",   32'(grant),   32'(eg));
    check("select",  32'(select),  32'(es));
    check("valid",   32'(valid),   32'(m_owner >= 0));
    check("timeout", 32'(timeout), 32'(m_to));
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic rs, input logic [2:0] rq, input logic dn);
    reset = rs;
    req   = rq;
    done  = dn;
    @(posedge clk);
    model_edge(rs, rq, dn);
    #1;
    check_outputs();
  endtask

  initial begin
    // Reset held 3 cycles with all requesting.
    for (int i = 0; i < 3; i++) step(1'b1, 3'b111, 1'b0);
    check("rst_grant", 32'(grant), 32'h0);
    check("rst_select", 32'(select), 32'h3);

    // Release reset: requester 0 wins first.
    step(1'b0, 3'b111, 1'b0);
    check("first_grant", 32'(grant), 32'h1);

    // Rotation with done each ownership.
    step(1'b0, 3'b111, 1'b1);
    check("rot_1", 32'(grant), 32'h2);
    step(1'b0, 3'b111, 1'b1);
    check("rot_2", 32'(grant), 32'h4);
    check("rot_2_sel", 32'(select), 32'h2);
    step(1'b0, 3'b111, 1'b1);
    check("rot_3", 32'(grant), 32'h1);

    // Drop release: pass to owner 1, then everybody drops.
    step(1'b0, 3'b010, 1'b1);
    check("drop_own1", 32'(grant), 32'h2);
    step(1'b0, 3'b010, 1'b0);
    step(1'b0, 3'b000, 1'b0);
    check("drop_idle", 32'(select), 32'h3);
    step(1'b0, 3'b000, 1'b1);     // done while idle is ignored
    step(1'b0, 3'b001, 1'b0);
    check("drop_regrant", 32'(grant), 32'h1);

    // Single requester re-grant with done, then non-owners raised mid-hold.
    step(1'b0, 3'b100, 1'b0);
    check("single_own2", 32'(grant), 32'h4);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 3'b100, 1'b1);
      check("single_hold", 32'(grant), 32'h4);
    end
    step(1'b0, 3'b111, 1'b0);
    check("nonowner_ignored", 32'(grant), 32'h4);
    step(1'b0, 3'b111, 1'b1);
    check("after_done", 32'(grant), 32'h1);

    // Long hold without done: forced release only with the timeout option.
    step(1'b1, 3'b000, 1'b0);
    for (int i = 0; i < 12; i++) step(1'b0, 3'b011, 1'b0);
`ifndef ARB_TIMEOUT_EN
    check("long_hold", 32'(grant), 32'h1);
    check("long_hold_to", 32'(timeout), 32'h0);
`endif

    // Mid-operation reset while owner 1 busy.
    step(1'b1, 3'b000, 1'b0);
    step(1'b0, 3'b111, 1'b0);
    step(1'b0, 3'b111, 1'b1);
    check("mid_busy1", 32'(grant), 32'h2);
    step(1'b1, 3'b110, 1'b0);
    check("mid_rst", 32'(valid), 32'h0);
    step(1'b0, 3'b110, 1'b0);
    check("mid_after", 32'(grant), 32'h2);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 63) == 0),
           3'($urandom_range(0, 7)),
           ($urandom_range(0, 3) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
